// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: owner and FSM state encodings,
// plus a helper that sizes small saturating counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
// slave = arbiter side, master = requesters plus memory array side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // req/ready: a requester raises req with we/addr/wdata stable and holds them
  // until a one-cycle ready pulse; rdata is meaningful only while ready=1.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_fair.sv
// Winner pick for the arbiter: CPU has priority, but after STARVE_MAX
// consecutive CPU wins over a waiting DMA the DMA takes the next decision.
module mem_arb_fair
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic decide,
  output logic grant_cpu,
  output logic grant_dma
);

  localparam int CW = ctr_width(STARVE_MAX);
  localparam logic [CW-1:0] CTR_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] ctr_q, ctr_d;

  always_comb begin
    grant_dma = decide && dma_req && (!cpu_req || (ctr_q == CTR_MAX));
    grant_cpu = decide && cpu_req && !grant_dma;
    ctr_d     = ctr_q;
    // Only a CPU win over a pending DMA ages the counter; anything else resets it.
    if (decide) begin
      if (grant_cpu && dma_req) begin
        ctr_d = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + 1'b1;
      end else begin
        ctr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between a CPU port and a DMA port. One access at a time:
// decide in IDLE, strobe the memory in ISSUE, wait out read latency, pulse ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output owner_t        owner,
  output arb_state_t    state_dbg
);

  localparam int LW = ctr_width(RD_LAT);

  arb_state_t    state_q;
  owner_t        owner_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          cpu_ready_q;
  logic          dma_ready_q;
  logic [LW-1:0] lat_q;
  logic          grant_cpu;
  logic          grant_dma;

  mem_arb_fair #(
    .STARVE_MAX(STARVE_MAX)
  ) u_fair (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (bus.cpu_req),
    .dma_req  (bus.dma_req),
    .decide   (state_q == IDLE),
    .grant_cpu(grant_cpu),
    .grant_dma(grant_dma)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      lat_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dma) begin
            state_q     <= ISSUE;
            owner_q     <= OWN_DMA;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dma_we;
            mem_addr_q  <= bus.dma_addr;
            mem_wdata_q <= bus.dma_wdata;
          end else if (grant_cpu) begin
            state_q     <= ISSUE;
            owner_q     <= OWN_CPU;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.cpu_we;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          // mem_we_q still holds the latched direction during ISSUE.
          if (mem_we_q || (RD_LAT == 1)) begin
            state_q     <= DONE;
            cpu_ready_q <= (owner_q == OWN_CPU);
            dma_ready_q <= (owner_q == OWN_DMA);
          end else begin
            state_q <= WAIT;
            lat_q   <= LW'(RD_LAT - 2);
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            state_q     <= DONE;
            cpu_ready_q <= (owner_q == OWN_CPU);
            dma_ready_q <= (owner_q == OWN_DMA);
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          owner_q     <= OWN_NONE;
          cpu_ready_q <= 1'b0;
          dma_ready_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
  assign owner         = owner_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random CPU/DMA traffic against a
// transaction-level model; a monitor checks memory strobes and ready pulses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  owner_t     owner;
  arb_state_t state_dbg;

  mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .owner    (owner),
    .state_dbg(state_dbg)
  );

  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  assign bus.cpu_req   = req[0];
  assign bus.cpu_we    = we[0];
  assign bus.cpu_addr  = addr[0];
  assign bus.cpu_wdata = wdata[0];
  assign bus.dma_req   = req[1];
  assign bus.dma_we    = we[1];
  assign bus.dma_addr  = addr[1];
  assign bus.dma_wdata = wdata[1];

  // ---------------- memory array model ----------------
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function logic [DW-1:0] phys_read(input logic [AW-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? phys_read(bus.mem_addr) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic port_ready(input int p);
    return (p == 1) ? bus.dma_ready : bus.cpu_ready;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    longint        issue;
    longint        done;
  } txn_t;

  txn_t   iss_q[$];
  txn_t   exp_q[$];
  int     grant_log[$];
  bit     model_en  = 1'b0;
  longint next_dec  = 0;
  int     sc        = 0;
  int     cur_port  = -1;
  longint cur_issue = 0;
  longint cur_done  = -1;
  int     m_p;
  txn_t   m_t;

  // Transaction-level view: a grant at decision cycle T issues at T+1 and
  // completes at T+2 (write) or T+1+RD_LAT (read); next decision follows.
  always @(negedge clk) begin
    if (model_en && cyc == next_dec) begin
      if (req[1] && (!req[0] || sc == STARVE_MAX)) m_p = 1;
      else if (req[0])                              m_p = 0;
      else                                          m_p = -1;
      if (m_p == 0 && req[1]) sc = (sc < STARVE_MAX) ? sc + 1 : sc;
      else                    sc = 0;
      if (m_p < 0) begin
        next_dec = cyc + 1;
      end else begin
        m_t.port  = m_p;
        m_t.we    = we[m_p];
        m_t.addr  = addr[m_p];
        m_t.wdata = wdata[m_p];
        m_t.issue = cyc + 1;
        m_t.done  = m_t.we ? cyc + 2 : cyc + 1 + RD_LAT;
        if (m_t.we) begin
          ref_mem[m_t.addr] = m_t.wdata;
          m_t.rdata = '0;
        end else begin
          m_t.rdata = ref_read(m_t.addr);
        end
        iss_q.push_back(m_t);
        exp_q.push_back(m_t);
        cur_port  = m_p;
        cur_issue = m_t.issue;
        cur_done  = m_t.done;
        next_dec  = m_t.done + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  txn_t mon_t;
  int   mon_p;

  always @(negedge clk) begin
    if (model_en) begin
      check("owner", owner,
            (cur_port >= 0 && cyc >= cur_issue && cyc <= cur_done) ? 64'(cur_port + 1) : 64'd0);
      check("single_ready", 64'(bus.cpu_ready & bus.dma_ready), 64'd0);
      if (bus.mem_en) begin
        if (iss_q.size() == 0) begin
          fail_now("unexpected_mem_en");
        end else begin
          mon_t = iss_q.pop_front();
          check("issue_cycle", cyc, mon_t.issue);
          check("mem_we", bus.mem_we, mon_t.we);
          check("mem_addr", bus.mem_addr, mon_t.addr);
          if (mon_t.we) check("mem_wdata", bus.mem_wdata, mon_t.wdata);
        end
      end
      if (bus.cpu_ready || bus.dma_ready) begin
        mon_p = bus.dma_ready ? 1 : 0;
        grant_log.push_back(mon_p);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_ready");
        end else begin
          mon_t = exp_q.pop_front();
          check("ready_port", 64'(mon_p), 64'(mon_t.port));
          check("ready_cycle", cyc, mon_t.done);
          if (!mon_t.we)
            check("rdata", mon_p ? bus.dma_rdata : bus.cpu_rdata, mon_t.rdata);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_txn(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit keep);
    int budget;
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    budget   = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!port_ready(p) && budget < 200);
    if (!port_ready(p)) fail_now($sformatf("ready_timeout_port%0d", p));
    @(posedge clk);
    #1;
    if (!keep) req[p] = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15) * 4);
  endfunction

  task automatic random_port(input int p, input int n);
    bit k;
    for (int i = 0; i < n; i++) begin
      k = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_txn(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom, k);
      if (!k) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    fail_now("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int     budget;
    longint rc;
    int     exp_order[6];
    exp_order = '{0, 0, 0, 0, 1, 0};
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, IDLE);
    check("rst_owner", owner, OWN_NONE);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_dma_ready", bus.dma_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset in the ISSUE cycle of a CPU read aborts it; held req re-arbitrates
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h80;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.mem_en && budget < 20);
    check("abort_issue_seen", bus.mem_en, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_en", bus.mem_en, 1'b0);
    check("abort_mem_addr", bus.mem_addr, '0);
    check("abort_owner", owner, OWN_NONE);
    check("abort_state", state_dbg, IDLE);
    check("abort_cpu_ready", bus.cpu_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc = cyc;
    for (int i = 0; i <= RD_LAT + 1; i++) begin
      @(negedge clk);
      check("reissue_mem_en", bus.mem_en, 1'(cyc == rc + 1));
      if (cyc == rc + 1) check("reissue_addr", bus.mem_addr, 32'h80);
      check("reissue_cpu_ready", bus.cpu_ready, 1'(cyc == rc + 1 + RD_LAT));
      if (bus.cpu_ready) check("reissue_rdata", bus.cpu_rdata, init_word(32'h80));
      check("reissue_dma_ready", bus.dma_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    req[0] = 1'b0;

    // Clean restart, model takes over
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    next_dec = cyc;
    sc       = 0;
    model_en = 1'b1;

    // CPU read alone, DMA write alone, CPU read then DMA write
    drive_txn(0, 1'b0, 32'h40, '0, 1'b0);
    drive_txn(1, 1'b1, 32'h100, 32'h12345678, 1'b0);
    check("dma_write_landed", phys_read(32'h100), 32'h12345678);
    drive_txn(0, 1'b0, 32'h100, '0, 1'b0);
    drive_txn(1, 1'b1, 32'h104, 32'h0BADF00D, 1'b0);

    // Simultaneous requests
    fork
      drive_txn(0, 1'b0, 32'h48, '0, 1'b0);
      drive_txn(1, 1'b1, 32'h108, 32'hCAFEF00D, 1'b0);
    join

    // Starvation bound: CPU back-to-back against a waiting DMA
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive_txn(0, 1'b0, AW'(32'h10 + 4 * i), '0, i < 4);
      end
      drive_txn(1, 1'b1, 32'h200, 32'hA5A50001, 1'b0);
    join
    check("starve_grants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) check($sformatf("starve_order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

    // Random traffic on both ports
    fork
      random_port(0, 30);
      random_port(1, 30);
    join

    repeat (RD_LAT + 4) @(posedge clk);
    @(negedge clk);
    check("iss_q_drained", 64'(iss_q.size()), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
